// File: rtl/cpu_pkg.sv
// Shared fetch-side defaults, FSM state encoding and the instruction-window check.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam int unsigned IM_WORDS_DEF   = 4096;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } if_state_e;

  // 33-bit compare so a window ending exactly at 2^32 is still handled.
  function automatic logic im_addr_ok(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned words);
    logic [32:0] lim;
    lim = {1'b0, base} + ({1'b0, words} << 2);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/if_fifo2.sv
// Two-entry shift FIFO with flush; push and pop may coincide, including when full.
module if_fifo2 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        push_exc,
  input  logic        pop,
  output logic [1:0]  count,
  output logic [31:0] head_instr,
  output logic [31:0] head_pc,
  output logic        head_exc
);

  logic [64:0] slot0_q, slot0_d;
  logic [64:0] slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;
  logic [64:0] push_ent;
  logic        pop_ok;
  logic        push_ok;

  assign push_ent = {push_exc, push_pc, push_instr};
  assign pop_ok   = pop && (count_q != 2'd0);
  assign push_ok  = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_ent;
          else                 slot1_d = push_ent;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_ent;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_exc   = slot0_q[64];
  assign head_pc    = slot0_q[63:32];
  assign head_instr = slot0_q[31:0];

endmodule

// File: rtl/if_ctrl.sv
// Instruction fetch controller: PC sequencing, fetch-error halt and control redirects
// into a 2-entry decode FIFO. Define IF_CTRL_PERF_EN to add perf_fetch/perf_stall.
//
// state    | meaning
// ST_FETCH | fetching at pc whenever the FIFO has (or is freeing) a slot
// ST_HALT  | fetch error seen; pc frozen until exc_req / eret / redirect
module if_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned IM_WORDS   = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] ima,
  input  logic [31:0] imd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_exc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc
`ifdef IF_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count;
  logic        pop;
  logic        ctrl;
  logic        push;
  logic        fetch_ok;
  logic [31:0] push_instr;

  assign ima        = pc_q;
  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign ctrl       = exc_req || eret || redirect;
  assign fetch_ok   = im_addr_ok(pc_q, RESET_PC, IM_WORDS);
  assign push       = (state_q == ST_FETCH) && !ctrl && ((count != 2'd2) || pop);
  assign push_instr = fetch_ok ? imd : 32'h0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      state_d = ST_FETCH;
    end else if (eret) begin
      pc_d    = epc;
      state_d = ST_FETCH;
    end else if (redirect) begin
      pc_d    = redirect_pc;
      state_d = ST_FETCH;
    end else if (push) begin
      if (fetch_ok) pc_d = pc_q + 32'd4;
      else          state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Flushing on any control event also covers a coincident pop: the head word was
  // already presented, so the consumer keeps it while the rest is discarded.
  if_fifo2 u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (ctrl),
    .push       (push),
    .push_instr (push_instr),
    .push_pc    (pc_q),
    .push_exc   (!fetch_ok),
    .pop        (pop),
    .count      (count),
    .head_instr (out_instr),
    .head_pc    (out_pc),
    .head_exc   (out_exc)
  );

`ifdef IF_CTRL_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, push && fetch_ok};
    perf_stall_d = perf_stall_q +
                   {31'd0, (state_q == ST_FETCH) && !ctrl && (count == 2'd2) && !pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
